fetch_unit: RTL and testbench

Instruction-fetch stage that directly feeds the main/ALU decoder.
- Owns the PC and instruction register (IR) and issues requests to instruction memory over a req/ready handshake.
- Slices the held instruction into opcode, funct and register fields for the decoder and datapath.
- Computes the next PC from the decoder's branch/jump outputs and the ALU zero flag.
- Multi-cycle flavour: at most one instruction in flight and one held.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/pc_next_calc.sv | 38 +++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path: fetch FSM states,
// reset vector default, decoder opcodes and the instruction field layout.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetchState_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;

   // R-type view of a 32-bit instruction word, MSB first
   typedef struct packed {
      logic [5:0] opcode;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
   } instrFields_t;

   function automatic logic signed [31:0] signExt16(input logic [15:0] value);
      return {{16{value[15]}}, value};
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the fetch stage: jump beats a taken
// branch, which beats sequential flow. All arithmetic wraps modulo 2^32.
module pc_next_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] pcPlus4,
   output logic [31:0] nextPc
);

   logic signed [31:0] immSext;
   logic signed [31:0] branchOffset;
   logic [31:0]        branchTarget;
   logic [31:0]        jumpTarget;
   logic               unusedOpcode;

   assign pcPlus4      = pc + 32'd4;
   assign immSext      = signExt16(instr[15:0]);
   assign branchOffset = immSext <<< 2;
   assign branchTarget = pcPlus4 + $unsigned(branchOffset);
   // Jump keeps the 256 MB region of the delay-slot address
   assign jumpTarget   = {pcPlus4[31:28], instr[25:0], 2'b00};
   assign unusedOpcode = ^instr[31:26];

   always_comb begin
      nextPc = pcPlus4;
      if (jump) begin
         nextPc = jumpTarget;
      end else if (branch && zero) begin
         nextPc = branchTarget;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: owns PC and IR, handshakes with instruction
// memory, exposes decoded instruction fields and a retired-instruction count.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ready,
   input  logic [31:0]        imem_rdata,
   input  logic               stall,
   input  logic               branch,
   input  logic               zero,
   input  logic               jump,
   output logic               instr_valid,
   output logic [31:0]        instr,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   output logic [5:0]         opcode,
   output logic [5:0]         funct,
   output logic [4:0]         rs,
   output logic [4:0]         rt,
   output logic [4:0]         rd,
   output logic [4:0]         shamt,
   output logic [31:0]        imm_sext,
   output logic [COUNT_W-1:0] retired
);

   fetchState_t        state;
   logic [31:0]        pcReg;
   logic [31:0]        irReg;
   logic               reqReg;
   logic               validReg;
   logic [COUNT_W-1:0] retiredReg;
   logic [31:0]        nextPc;
   instrFields_t       fields;

   pc_next_calc uNextPc (
      .pc      (pcReg),
      .instr   (irReg),
      .branch  (branch),
      .zero    (zero),
      .jump    (jump),
      .pcPlus4 (pc_plus4),
      .nextPc  (nextPc)
   );

   // IDLE gives one dead cycle after reset; FETCH waits for memory; HOLD
   // presents the instruction until downstream consumes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pcReg      <= RESET_PC;
         irReg      <= 32'h0;
         reqReg     <= 1'b0;
         validReg   <= 1'b0;
         retiredReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               state  <= FETCH;
               reqReg <= 1'b1;
            end
            FETCH: begin
               if (imem_ready) begin
                  irReg    <= imem_rdata;
                  validReg <= 1'b1;
                  reqReg   <= 1'b0;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (!stall) begin
                  pcReg      <= nextPc;
                  validReg   <= 1'b0;
                  retiredReg <= retiredReg + COUNT_W'(1);
                  reqReg     <= 1'b1;
                  state      <= FETCH;
               end
            end
            default: begin
               state    <= IDLE;
               reqReg   <= 1'b0;
               validReg <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = reqReg;
   assign imem_addr   = pcReg;
   assign instr_valid = validReg;
   assign instr       = irReg;
   assign pc          = pcReg;
   assign retired     = retiredReg;

   assign fields   = irReg;
   assign opcode   = fields.opcode;
   assign rs       = fields.rs;
   assign rt       = fields.rt;
   assign rd       = fields.rd;
   assign shamt    = fields.shamt;
   assign funct    = fields.funct;
   assign imm_sext = signExt16(irReg[15:0]);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios on three reset vectors, then a
// randomized run checked by a queue-based scoreboard against a program-level model.
module tb_fetch_unit;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imemReady = 1'b0;
   logic [31:0] imemRdata = 32'h0;
   logic        stall = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic        jump = 1'b0;

   logic        req   [N];
   logic [31:0] addr  [N];
   logic        vld   [N];
   logic [31:0] ins   [N];
   logic [31:0] pc    [N];
   logic [31:0] pcp4  [N];
   logic [5:0]  opc   [N];
   logic [5:0]  fun   [N];
   logic [4:0]  rs    [N];
   logic [4:0]  rt    [N];
   logic [4:0]  rd    [N];
   logic [4:0]  sh    [N];
   logic [31:0] imm   [N];
   logic [31:0] ret   [N];

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : gDut
         localparam logic [31:0] RP = (g == 0) ? 32'h0000_0000 :
                                      (g == 1) ? 32'hFFFF_FFFC : 32'h1000_0000;
         fetch_unit #(.RESET_PC(RP), .COUNT_W(32)) dut (
            .clk         (clk),
            .reset       (reset),
            .imem_req    (req[g]),
            .imem_addr   (addr[g]),
            .imem_ready  (imemReady),
            .imem_rdata  (imemRdata),
            .stall       (stall),
            .branch      (branch),
            .zero        (zero),
            .jump        (jump),
            .instr_valid (vld[g]),
            .instr       (ins[g]),
            .pc          (pc[g]),
            .pc_plus4    (pcp4[g]),
            .opcode      (opc[g]),
            .funct       (fun[g]),
            .rs          (rs[g]),
            .rt          (rt[g]),
            .rd          (rd[g]),
            .shamt       (sh[g]),
            .imm_sext    (imm[g]),
            .retired     (ret[g])
         );
      end
   endgenerate

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: expected fetch addresses and expected held instructions
   typedef struct {
      logic [31:0] pc;
      logic [31:0] w;
      logic [31:0] ret;
   } heldT;

   logic [31:0] fetchQ [$];
   heldT        heldQ [$];
   logic        sbOn = 1'b0;
   logic [31:0] fe;
   heldT        he;

   always @(negedge clk) begin
      if (sbOn) begin
         if (req[0] && imemReady) begin
            if (fetchQ.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_fetch_unexpected actual=%h required=none", addr[0]);
            end else begin
               fe = fetchQ.pop_front();
               chk("sb_fetch_addr", addr[0], fe);
            end
         end
         if (vld[0] && !stall) begin
            if (heldQ.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_consume_unexpected actual=%h required=none", ins[0]);
            end else begin
               he = heldQ.pop_front();
               chk("sb_instr",   ins[0], he.w);
               chk("sb_pc",      pc[0], he.pc);
               chk("sb_pc4",     pcp4[0], he.pc + 32'd4);
               chk("sb_retired", ret[0], he.ret);
               chk("sb_opcode",  32'(opc[0]), 32'(he.w[31:26]));
               chk("sb_rs",      32'(rs[0]), 32'(he.w[25:21]));
               chk("sb_rt",      32'(rt[0]), 32'(he.w[20:16]));
               chk("sb_rd",      32'(rd[0]), 32'(he.w[15:11]));
               chk("sb_shamt",   32'(sh[0]), 32'(he.w[10:6]));
               chk("sb_funct",   32'(fun[0]), 32'(he.w[5:0]));
               chk("sb_imm",     imm[0], 32'($signed(he.w[15:0])));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   logic [31:0] hsA [3];
   logic [31:0] hsB [3];
   int          nHs;
   logic        seen;
   logic [31:0] pcS, rS;
   logic [31:0] modelPc, modelRet, w, p4;
   int          k, d, s;
   logic        jf, bf, zf;

   initial begin : main
      // Reset state
      repeat (2) tick();
      chk("rst_req",    32'(req[0]), 32'h0);
      chk("rst_vld",    32'(vld[0]), 32'h0);
      chk("rst_pc",     pc[0], 32'h0);
      chk("rst_instr",  ins[0], 32'h0);
      chk("rst_ret",    ret[0], 32'h0);
      chk("rst_opcode", 32'(opc[0]), 32'h0);
      chk("rst_imm",    imm[0], 32'h0);
      chk("rst_pc_hi",  pc[1], 32'hFFFF_FFFC);
      chk("rst_pc4_wrap", pcp4[1], 32'h0);
      chk("rst_pc_mid", pc[2], 32'h1000_0000);

      // Back-to-back fetch, memory always ready
      imemRdata = 32'h2008_0005;
      imemReady = 1'b1;
      reset = 1'b0;
      chk("dead_cycle_req", 32'(req[0]), 32'h0);
      nHs = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && ret[0] != 32'd3; c++) begin
         tick();
         if (req[0] && imemReady && nHs < 3) begin
            hsA[nHs] = addr[0];
            hsB[nHs] = addr[1];
            nHs++;
         end
         if (vld[0] && !seen) begin
            chk("seq_opcode", 32'(opc[0]), 32'h8);
            chk("seq_rt",     32'(rt[0]), 32'h8);
            chk("seq_rs",     32'(rs[0]), 32'h0);
            chk("seq_imm",    imm[0], 32'h5);
            seen = 1'b1;
         end
      end
      imemReady = 1'b0;
      chk("seq_nhs",   32'(nHs), 32'd3);
      chk("seq_addr0", hsA[0], 32'h0);
      chk("seq_addr1", hsA[1], 32'h4);
      chk("seq_addr2", hsA[2], 32'h8);
      chk("wrap_addr0", hsB[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", hsB[1], 32'h0);
      chk("seq_ret3",  ret[0], 32'd3);
      chk("seq_next",  addr[0], 32'hC);

      // Reset mid-FETCH with memory answering: takes effect before the edge
      reset = 1'b1;
      imemReady = 1'b1;
      imemRdata = 32'hDEAD_BEEF;
      #1;
      chk("midf_pc",  pc[0], 32'h0);
      chk("midf_vld", 32'(vld[0]), 32'h0);
      chk("midf_req", 32'(req[0]), 32'h0);
      tick();
      chk("midf_nocap", ins[0], 32'h0);
      reset = 1'b0;
      imemReady = 1'b0;
      chk("midf_idle_req", 32'(req[0]), 32'h0);

      // Memory answers after three wait cycles
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wait_req",  32'(req[0]), 32'h1);
         chk("wait_addr", addr[0], 32'h0);
         chk("wait_vld",  32'(vld[0]), 32'h0);
         if (i == 3) begin
            imemReady = 1'b1;
            imemRdata = 32'h0800_0010;
         end
      end
      tick();
      imemReady = 1'b0;
      chk("wait_vld_rise", 32'(vld[0]), 32'h1);
      chk("wait_instr",    ins[0], 32'h0800_0010);
      chk("hold_req",      32'(req[0]), 32'h0);
      jump = 1'b1;
      tick();
      jump = 1'b0;
      chk("jump_addr", addr[0], 32'h40);

      // beq backwards, taken
      imemReady = 1'b1;
      imemRdata = 32'h1022_FFFE;
      tick();
      imemReady = 1'b0;
      chk("beq_imm", imm[0], 32'hFFFF_FFFE);
      branch = 1'b1;
      zero = 1'b1;
      tick();
      chk("beq_taken", addr[0], 32'h3C);
      branch = 1'b0;
      zero = 1'b0;
      imemReady = 1'b1;
      imemRdata = 32'h0800_0010;
      tick();
      imemReady = 1'b0;
      jump = 1'b1;
      tick();
      jump = 1'b0;
      chk("jump_back", addr[0], 32'h40);
      imemReady = 1'b1;
      imemRdata = 32'h1022_FFFE;
      tick();
      imemReady = 1'b0;
      branch = 1'b1;
      zero = 1'b0;
      tick();
      branch = 1'b0;
      chk("beq_not_taken", addr[0], 32'h44);

      // Stall in HOLD for five cycles, with noise on ignored inputs
      stall = 1'b1;
      imemReady = 1'b1;
      imemRdata = 32'h0123_4567;
      tick();
      pcS = pc[0];
      rS = ret[0];
      for (int i = 0; i < 5; i++) begin
         imemReady = ($urandom_range(1) == 1);
         imemRdata = $urandom;
         jump = ($urandom_range(1) == 1);
         branch = ($urandom_range(1) == 1);
         zero = ($urandom_range(1) == 1);
         tick();
         chk("stall_vld",   32'(vld[0]), 32'h1);
         chk("stall_req",   32'(req[0]), 32'h0);
         chk("stall_instr", ins[0], 32'h0123_4567);
         chk("stall_pc",    pc[0], pcS);
         chk("stall_ret",   ret[0], rS);
      end
      imemReady = 1'b0;
      jump = 1'b0;
      branch = 1'b0;
      zero = 1'b0;
      stall = 1'b0;
      tick();
      chk("unstall_ret", ret[0], rS + 32'd1);
      chk("unstall_pc",  pc[0], 32'h48);
      chk("unstall_req", 32'(req[0]), 32'h1);
      chk("unstall_vld", 32'(vld[0]), 32'h0);
      tick();
      chk("once_pc",  pc[0], 32'h48);
      chk("once_ret", ret[0], rS + 32'd1);

      // Jump wins over a taken branch
      reset = 1'b1;
      tick();
      reset = 1'b0;
      imemReady = 1'b1;
      imemRdata = 32'h0800_0010;
      tick();
      tick();
      imemReady = 1'b0;
      jump = 1'b1;
      branch = 1'b1;
      zero = 1'b1;
      tick();
      jump = 1'b0;
      branch = 1'b0;
      zero = 1'b0;
      chk("jwin_addr_mid", addr[2], 32'h1000_0040);
      chk("jwin_addr_lo",  addr[0], 32'h40);
      chk("jwin_addr_hi",  addr[1], 32'h40);

      // Reset mid-HOLD
      imemReady = 1'b1;
      imemRdata = 32'hCAFE_F00D;
      tick();
      imemReady = 1'b0;
      stall = 1'b1;
      chk("midh_held", ins[0], 32'hCAFE_F00D);
      reset = 1'b1;
      #1;
      chk("midh_vld",   32'(vld[0]), 32'h0);
      chk("midh_instr", ins[0], 32'h0);
      chk("midh_pc",    pc[0], 32'h0);
      tick();
      reset = 1'b0;
      stall = 1'b0;

      // Randomized program run under the scoreboard
      modelPc = 32'h0;
      modelRet = 32'h0;
      fetchQ.push_back(modelPc);
      sbOn = 1'b1;
      for (int t = 0; t < 150; t++) begin
         k = 0;
         while (!req[0] && k < 8) begin
            tick();
            k++;
         end
         if (!req[0]) begin
            checks++;
            failures++;
            $display("FAIL sb_req_timeout actual=0 required=1");
            break;
         end
         w = $urandom;
         case ($urandom_range(3))
            0: w[31:26] = 6'b000010;
            1: w[31:26] = 6'b000100;
            default: ;
         endcase
         heldQ.push_back('{pc: modelPc, w: w, ret: modelRet});
         d = $urandom_range(3);
         for (int i = 0; i < d; i++) begin
            imemRdata = $urandom;
            tick();
         end
         imemReady = 1'b1;
         imemRdata = w;
         tick();
         s = $urandom_range(2);
         stall = 1'b1;
         for (int i = 0; i < s; i++) begin
            imemReady = ($urandom_range(1) == 1);
            imemRdata = $urandom;
            jump = ($urandom_range(1) == 1);
            branch = ($urandom_range(1) == 1);
            zero = ($urandom_range(1) == 1);
            tick();
         end
         imemReady = 1'b0;
         jf = ($urandom_range(3) == 0);
         bf = ($urandom_range(1) == 1);
         zf = ($urandom_range(1) == 1);
         jump = jf;
         branch = bf;
         zero = zf;
         stall = 1'b0;
         p4 = modelPc + 32'd4;
         if (jf)
            modelPc = (p4 & 32'hF000_0000) + 32'(w[25:0]) * 32'd4;
         else if (bf && zf)
            modelPc = p4 + 32'($signed(w[15:0])) * 32'd4;
         else
            modelPc = p4;
         modelRet = modelRet + 32'd1;
         fetchQ.push_back(modelPc);
         tick();
         jump = 1'b0;
         branch = 1'b0;
         zero = 1'b0;
      end
      repeat (3) tick();
      sbOn = 1'b0;
      chk("sb_held_drained", 32'(heldQ.size()), 32'd0);
      chk("sb_fetch_left",   32'(fetchQ.size()), 32'd1);
      chk("sb_final_ret",    ret[0], modelRet);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
